instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: ADDR_W, 6, word-address width of target instruction memory (depth 2**ADDR_W).
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  one-cycle pulse; opens a program session at word address 0.
REQ-005 SHALL have port: finish  input  1  one-cycle pulse; closes the session.
REQ-006 SHALL have port: in_valid  input  1  instruction request valid.
REQ-007 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready.
REQ-008 SHALL have port: in_class  input  3  0=LW 1=SW 2=BEQ 3=ADDI 4=J 5=JAL 6=R-type 7=JR.
REQ-009 SHALL have port: in_func  input  4  R-type op: 0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=MULTU 6=DIVU 7=MFHI 8=MFLO; others illegal.
REQ-010 SHALL have port: in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-011 SHALL have port: in_imm  input  16  immediate/offset.
REQ-012 SHALL have port: in_target  input  26  jump target.
REQ-013 SHALL have port: imem_we  output  1  instruction-memory write strobe.
REQ-014 SHALL have port: imem_addr  output  ADDR_W  word address of write.
REQ-015 SHALL have port: imem_wdata  output  32  encoded instruction.
REQ-016 SHALL have port: count  output  ADDR_W+1  instructions written this session.
REQ-017 SHALL have port: full, done, err  output  1 each  memory full; session-closed pulse; sticky illegal-request flag.

Function
REQ-018 SHALL implement states IDLE, RUN, FULL; in_ready=1 only in RUN.
REQ-019 IDLE: start -> RUN, write pointer=0, count=0, err=0; in_valid ignored.
REQ-020 Accepted request in cycle N SHALL produce imem_we=1 with registered addr/wdata in cycle N+1 (latency 1, one write per accept, back-to-back accepts allowed).
REQ-021 Encodings: LW {23h,rs,rt,imm}; SW {2Bh,rs,rt,imm}; BEQ {04h,rs,rt,imm}; ADDI {08h,rs,rt,imm}; J {02h,target}; JAL {03h,target}.
REQ-022 R-type: {00h,rs,rt,rd,5'b0,funct}, funct ADD 20h, SUB 22h, AND 24h, OR 25h, SLT 2Ah, MULTU 19h, DIVU 1Bh, MFHI 10h, MFLO 12h.
REQ-023 Field forcing: MULTU/DIVU rd=0; MFHI/MFLO rs=rt=0; JR {00h,rs,15'b0,08h}.
REQ-024 Illegal in_func on class 6: request consumed, no write, pointer/count unchanged, err set until next start or reset.
REQ-025 Each write SHALL increment pointer and count; pointer never wraps.
REQ-026 Write to address 2**ADDR_W-1 SHALL move RUN -> FULL in same cycle as that write; full=1 in FULL.
REQ-027 finish in RUN or FULL -> IDLE next cycle, done=1 for exactly one cycle; a write pending from the prior-cycle accept still completes.
REQ-028 finish and in_valid in same cycle: request accepted and written, then IDLE.
REQ-029 start while RUN/FULL SHALL restart session (pointer=0, count=0, err=0, full=0); simultaneous accept that cycle discarded.
REQ-030 start and finish together: start wins.
REQ-031 imem_we SHALL be 0 in every cycle with no pending write; imem_addr/wdata hold last value.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, done=0, err=0, including mid-session; any pending write dropped.

Verification
REQ-033 start; ADDI rs=1 rt=2 imm=0005h -> next cycle imem_we=1, addr=0, wdata=20220005h, count=1.
REQ-034 R ADD rs=1 rt=2 rd=3, then LW rs=29 rt=8 imm=4, then J target=10h back-to-back -> wdata 00221820h @0, 8FA80004h @1, 08000010h @2, count=3.
REQ-035 R-type in_func=12 mid-stream -> no write, err=1, next legal request lands at unchanged address.
REQ-036 ADDR_W=2, four accepts -> last write addr=3, full=1, in_ready=0; finish -> done pulse, IDLE, count=4.
REQ-037 rst_n low during back-to-back stream -> all outputs zero same cycle, no further imem_we; after release, start restarts at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS-style instruction encoder writing a program into instruction memory
//
// Purpose: accepts instruction requests during a program session and writes
// their 32-bit encodings to consecutive instruction-memory words. Each write
// appears one cycle after its request is accepted.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, finish     one-cycle pulses that open / close a program session
//   in_valid/in_ready request handshake; in_ready is high only while running
//   in_class, in_func instruction class and R-type operation selector
//   in_rs/rt/rd       register fields
//   in_imm, in_target immediate/offset and jump target fields
//   imem_we/addr/wdata instruction-memory write port (registered)
//   count             instructions written in the current session
//   full, done, err   memory full; session-closed pulse; sticky illegal request
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [3:0]        in_func,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              done_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [5:0]        funct;
    logic              funct_ok;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;

    logic              accept;
    logic              write_fire;
    logic [ADDR_W-1:0] ptr;
    logic              last_word;

    // The pointer never wraps: the session goes FULL on the write to the last
    // word, so the low bits of count always equal the next write address.
    assign ptr        = count_q[ADDR_W-1:0];
    assign last_word  = (ptr == {ADDR_W{1'b1}});
    assign accept     = in_valid && (state == RUN);
    // A start in the same cycle discards the accepted request.
    assign write_fire = accept && enc_legal && !start;

    // R-type function code lookup and field forcing.
    always_comb begin
        funct    = 6'h00;
        funct_ok = 1'b1;
        r_rs     = in_rs;
        r_rt     = in_rt;
        r_rd     = in_rd;
        case (in_func)
            4'd0:    funct = 6'h20;
            4'd1:    funct = 6'h22;
            4'd2:    funct = 6'h24;
            4'd3:    funct = 6'h25;
            4'd4:    funct = 6'h2A;
            4'd5:    begin funct = 6'h19; r_rd = 5'd0; end
            4'd6:    begin funct = 6'h1B; r_rd = 5'd0; end
            4'd7:    begin funct = 6'h10; r_rs = 5'd0; r_rt = 5'd0; end
            4'd8:    begin funct = 6'h12; r_rs = 5'd0; r_rt = 5'd0; end
            default: funct_ok = 1'b0;
        endcase
    end

    // Instruction word assembly per class.
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (in_class)
            3'd0:    enc_word = {6'h23, in_rs, in_rt, in_imm};
            3'd1:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
            3'd2:    enc_word = {6'h04, in_rs, in_rt, in_imm};
            3'd3:    enc_word = {6'h08, in_rs, in_rt, in_imm};
            3'd4:    enc_word = {6'h02, in_target};
            3'd5:    enc_word = {6'h03, in_target};
            3'd6: begin
                enc_word  = {6'h00, r_rs, r_rt, r_rd, 5'b00000, funct};
                enc_legal = funct_ok;
            end
            default: enc_word = {6'h00, in_rs, 15'b0, 6'h08};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start beats finish; finish beats the move to FULL so a final write that
    // fills memory together with finish still closes the session.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (start)                                state_next = RUN;
                else if (finish)                          state_next = IDLE;
                else if (accept && enc_legal && last_word) state_next = FULL;
            end
            FULL: begin
                if (start)       state_next = RUN;
                else if (finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
        end else if (start) begin
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            done_q <= finish && (state != IDLE);
            we_q   <= write_fire;
            if (write_fire) begin
                addr_q  <= ptr;
                wdata_q <= enc_word;
                count_q <= count_q + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (accept && !enc_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign in_ready   = (state == RUN);
    assign full       = (state == FULL);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a behavioural model
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_class = '0;
    logic [3:0]    in_func = '0;
    logic [4:0]    in_rs = '0;
    logic [4:0]    in_rt = '0;
    logic [4:0]    in_rd = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          done;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_func    (in_func),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the instruction-set tables: returns {legal, word}.
    function automatic logic [32:0] model_enc(input logic [2:0] c, input logic [3:0] f,
                                              input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [15:0] imm,
                                              input logic [25:0] tg);
        logic [31:0] a, b, d, w, fc;
        logic        ok;
        a = 32'(rs); b = 32'(rt); d = 32'(rd); w = 0; ok = 1'b1; fc = 0;
        case (c)
            3'd0: w = (32'h23 << 26) | (a << 21) | (b << 16) | 32'(imm);
            3'd1: w = (32'h2B << 26) | (a << 21) | (b << 16) | 32'(imm);
            3'd2: w = (32'h04 << 26) | (a << 21) | (b << 16) | 32'(imm);
            3'd3: w = (32'h08 << 26) | (a << 21) | (b << 16) | 32'(imm);
            3'd4: w = (32'h02 << 26) | 32'(tg);
            3'd5: w = (32'h03 << 26) | 32'(tg);
            3'd6: begin
                case (f)
                    4'd0: fc = 32'h20;
                    4'd1: fc = 32'h22;
                    4'd2: fc = 32'h24;
                    4'd3: fc = 32'h25;
                    4'd4: fc = 32'h2A;
                    4'd5: fc = 32'h19;
                    4'd6: fc = 32'h1B;
                    4'd7: fc = 32'h10;
                    4'd8: fc = 32'h12;
                    default: ok = 1'b0;
                endcase
                if (f == 4'd5 || f == 4'd6) d = 0;
                if (f == 4'd7 || f == 4'd8) begin a = 0; b = 0; end
                w = (a << 21) | (b << 16) | (d << 11) | fc;
            end
            default: w = (a << 21) | 32'h08;
        endcase
        return {ok, w};
    endfunction

    // Behavioural session model: mode 0=idle 1=running 2=full.
    int          m_mode = 0;
    int          m_count = 0;
    bit          m_err = 1'b0;
    bit          m_we = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int          prev;
        bit          acc;
        logic [32:0] e;
        if (!rst_n) begin
            m_mode = 0; m_count = 0; m_err = 0; m_we = 0; m_done = 0;
            m_addr = 0; m_wdata = 0;
        end else begin
            prev = m_mode;
            acc  = in_valid && (prev == 1);
            e    = model_enc(in_class, in_func, in_rs, in_rt, in_rd, in_imm, in_target);
            if (start) begin
                m_mode = 1; m_count = 0; m_err = 0; m_we = 0; m_done = 0;
            end else begin
                m_done = finish && (prev != 0);
                m_we   = 0;
                if (acc) begin
                    if (!e[32]) begin
                        m_err = 1;
                    end else begin
                        m_we    = 1;
                        m_addr  = m_count;
                        m_wdata = e[31:0];
                        m_count = m_count + 1;
                        if (m_count == DEPTH) m_mode = 2;
                    end
                end
                if (finish && (prev != 0)) m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", 32'(in_ready), 32'(m_mode == 1));
            chk("m_full", 32'(full), 32'(m_mode == 2));
            chk("m_we", 32'(imem_we), 32'(m_we));
            chk("m_addr", 32'(imem_addr), m_addr);
            chk("m_wdata", imem_wdata, m_wdata);
            chk("m_count", 32'(count), 32'(m_count));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_err", 32'(err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] c, input logic [3:0] f, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tg);
        in_valid = 1'b1; in_class = c; in_func = f; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tg;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_we"}, 32'(imem_we), 0);
        chk({tag, "_addr"}, 32'(imem_addr), 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        repeat (2) cyc();
        chk_en = 1'b1;
        chk_zero("rst");
        rst_n = 1'b1;
        cyc();

        // First instruction of a session
        start = 1'b1; cyc(); start = 1'b0;
        chk("run_ready", 32'(in_ready), 1);
        req(3'd3, 4'd0, 5'd1, 5'd2, 5'd0, 16'h0005, 26'd0);
        cyc(); in_valid = 1'b0;
        chk("addi_we", 32'(imem_we), 1);
        chk("addi_addr", 32'(imem_addr), 0);
        chk("addi_wdata", imem_wdata, 32'h2022_0005);
        chk("addi_count", 32'(count), 1);
        cyc();
        chk("idle_we", 32'(imem_we), 0);
        chk("hold_wdata", imem_wdata, 32'h2022_0005);

        // Back-to-back stream
        start = 1'b1; cyc(); start = 1'b0;
        req(3'd6, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0); cyc();
        chk("add_wdata", imem_wdata, 32'h0022_1820);
        chk("add_addr", 32'(imem_addr), 0);
        req(3'd0, 4'd0, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0); cyc();
        chk("lw_wdata", imem_wdata, 32'h8FA8_0004);
        chk("lw_addr", 32'(imem_addr), 1);
        req(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10); cyc();
        chk("j_wdata", imem_wdata, 32'h0800_0010);
        chk("j_addr", 32'(imem_addr), 2);
        chk("j_count", 32'(count), 3);

        // Illegal R-type, then fill the last word
        req(3'd6, 4'd12, 5'd4, 5'd5, 5'd6, 16'h0, 26'd0); cyc();
        chk("ill_we", 32'(imem_we), 0);
        chk("ill_err", 32'(err), 1);
        chk("ill_count", 32'(count), 3);
        req(3'd3, 4'd0, 5'd3, 5'd4, 5'd0, 16'h0ABC, 26'd0); cyc(); in_valid = 1'b0;
        chk("last_addr", 32'(imem_addr), 3);
        chk("last_wdata", imem_wdata, 32'h2064_0ABC);
        chk("last_count", 32'(count), 4);
        chk("last_full", 32'(full), 1);
        chk("last_ready", 32'(in_ready), 0);
        finish = 1'b1; cyc(); finish = 1'b0;
        chk("fin_done", 32'(done), 1);
        chk("fin_full", 32'(full), 0);
        chk("fin_count", 32'(count), 4);
        cyc();
        chk("fin_done_clr", 32'(done), 0);

        // start and finish together: start wins
        start = 1'b1; finish = 1'b1; cyc(); start = 1'b0; finish = 1'b0;
        chk("sf_ready", 32'(in_ready), 1);
        chk("sf_done", 32'(done), 0);
        chk("sf_err", 32'(err), 0);

        // Reset in the middle of a stream
        req(3'd1, 4'd0, 5'd7, 5'd9, 5'd0, 16'hBEEF, 26'd0); cyc();
        req(3'd2, 4'd0, 5'd1, 5'd1, 5'd0, 16'hFFFF, 26'd0); cyc();
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        cyc();
        chk("midrst_we2", 32'(imem_we), 0);
        in_valid = 1'b0; rst_n = 1'b1; cyc();
        start = 1'b1; cyc(); start = 1'b0;
        req(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h1234, 26'd0); cyc(); in_valid = 1'b0;
        chk("post_addr", 32'(imem_addr), 0);
        chk("post_wdata", imem_wdata, 32'h8C00_1234);
        chk("post_count", 32'(count), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            start     = (m_mode == 0) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 3);
            finish    = ($urandom_range(0, 99) < 5);
            in_valid  = ($urandom_range(0, 99) < 70);
            in_class  = 3'($urandom);
            in_func   = 4'($urandom_range(0, 15));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_we", 32'(imem_we), 0);
                chk("rnd_rst_count", 32'(count), 0);
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
